// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the parametrised APB4 register-memory completer.
// Holds the FSM state encoding and the byte-strobe to bit-mask expansion.
package apb_mem_pkg;

  typedef enum logic [0:0] {IDLE, ACCESS} apb_st_e;

  // Expands up to 8 byte strobes into a 64-bit mask; callers size-cast to their data width.
  function automatic logic [63:0] strb_mask(input logic [7:0] strb);
    logic [63:0] m;
    m = '0;
    for (int b = 0; b < 8; b++) begin
      m[8*b +: 8] = {8{strb[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/apb_mem_slave_p_array.sv
// Word-addressed flop memory: asynchronous clear, masked byte write, combinational read.
module apb_mem_array
  import apb_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 16,
  parameter int IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      widx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] wmask,
  input  logic [IDX_W-1:0]      ridx,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // NOTE: this memory is small flop storage with a defined clear value, so it is reset
  // explicitly; a RAM macro could not be, which is why larger memories usually are not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[widx] <= (mem[widx] & ~wmask) | (wdata & wmask);
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/apb_mem_slave_p.sv
// APB4 completer in front of a small register memory at BASE_ADDR, with wait states,
// byte strobes, range/alignment decode, secure-write policy and protocol-violation flagging.
module apb_mem_slave_p
  import apb_mem_pkg::*;
#(
  parameter int                  ADDR_WIDTH  = 32,
  parameter int                  DATA_WIDTH  = 32,
  parameter int                  DATA_STRB   = DATA_WIDTH / 8,
  parameter int                  MEM_DEPTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'hA200_0000,
  parameter int                  WAIT_STATES = 0,
  parameter int                  SECURE_WR   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [2:0]            prot,
  input  logic                  pwrite,
  input  logic                  psel,
  input  logic                  penable,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_STRB-1:0]  pstrb,
  output logic                  pready,
  output logic                  slverr,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  prot_viol
);

  localparam int SH    = $clog2(DATA_STRB);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0]            WS      = 4'(WAIT_STATES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_M = ADDR_WIDTH'(DATA_STRB - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(MEM_DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic                  nsec;
  } req_t;

  apb_st_e st, st_nxt;
  logic [3:0] wcnt, wcnt_nxt;
  req_t a_q;
  logic latch;
  logic same_req;

  // Only prot[1] carries meaning for this target.
  logic unused_prot;
  assign unused_prot = ^{prot[2], prot[0]};

  assign same_req = psel & penable & (paddr == a_q.addr) & (pwrite == a_q.write);

  // NOTE: registered state uses non-blocking assignments so every flop samples the
  // pre-edge values, independent of the order the statements appear in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= IDLE;
      wcnt <= '0;
      a_q  <= '0;
    end else begin
      st   <= st_nxt;
      wcnt <= wcnt_nxt;
      if (latch) a_q <= '{addr: paddr, write: pwrite, nsec: prot[1]};
    end
  end

  // NOTE: every output of this block is given a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    st_nxt    = st;
    wcnt_nxt  = wcnt;
    latch     = 1'b0;
    pready    = 1'b0;
    prot_viol = 1'b0;
    unique case (st)
      IDLE: begin
        if (psel && !penable) begin
          latch    = 1'b1;
          wcnt_nxt = '0;
          st_nxt   = ACCESS;
        end
      end
      ACCESS: begin
        if (!same_req) begin
          prot_viol = 1'b1;
          st_nxt    = IDLE;
        end else if (wcnt != WS) begin
          wcnt_nxt = wcnt + 4'd1;
        end else begin
          pready = 1'b1;
          st_nxt = IDLE;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  // Decode is taken from the latched setup-phase request, not the live bus.
  logic [ADDR_WIDTH-1:0] off;
  logic [IDX_W-1:0]      idx;
  logic                  miss, perr, we;
  logic [DATA_WIDTH-1:0] rdata, wmask;

  assign off  = a_q.addr - BASE_ADDR;
  assign idx  = IDX_W'(off >> SH);
  assign miss = (a_q.addr < BASE_ADDR) | ((off >> SH) >= DEPTH_A) | ((off & ALIGN_M) != '0);
  assign perr = (SECURE_WR != 0) & a_q.write & a_q.nsec;

  assign slverr = pready & (miss | perr);
  assign we     = pready & a_q.write & ~slverr;
  assign wmask  = DATA_WIDTH'(strb_mask(8'(pstrb)));
  assign prdata = (pready & ~a_q.write & ~slverr) ? rdata : '0;

  apb_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .widx  (idx),
    .wdata (pwdata),
    .wmask (wmask),
    .ridx  (idx),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_apb_mem_slave_p.sv
// Scoreboard bench for apb_mem_slave_p: default, 3-wait-state and 64-bit instances share
// one APB bus with per-instance psel; expected responses are queued at drive time.
module tb_apb_mem_slave_p;

  localparam logic [31:0] BASE = 32'hA200_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] paddr;
  logic [2:0]  prot;
  logic        pwrite, penable;
  logic [2:0]  psel;
  logic [63:0] pwdata;
  logic [7:0]  pstrb;
  logic [2:0]  pready, slverr, viol;
  logic [31:0] prdata0, prdata1;
  logic [63:0] prdata2;

  always #5 clk = ~clk;

  apb_mem_slave_p dut0 (
    .clk(clk), .rst(rst), .paddr(paddr), .prot(prot), .pwrite(pwrite), .psel(psel[0]),
    .penable(penable), .pwdata(pwdata[31:0]), .pstrb(pstrb[3:0]), .pready(pready[0]),
    .slverr(slverr[0]), .prdata(prdata0), .prot_viol(viol[0])
  );

  apb_mem_slave_p #(.WAIT_STATES(3)) dut_ws (
    .clk(clk), .rst(rst), .paddr(paddr), .prot(prot), .pwrite(pwrite), .psel(psel[1]),
    .penable(penable), .pwdata(pwdata[31:0]), .pstrb(pstrb[3:0]), .pready(pready[1]),
    .slverr(slverr[1]), .prdata(prdata1), .prot_viol(viol[1])
  );

  apb_mem_slave_p #(.DATA_WIDTH(64), .MEM_DEPTH(8)) dut64 (
    .clk(clk), .rst(rst), .paddr(paddr), .prot(prot), .pwrite(pwrite), .psel(psel[2]),
    .penable(penable), .pwdata(pwdata), .pstrb(pstrb), .pready(pready[2]),
    .slverr(slverr[2]), .prdata(prdata2), .prot_viol(viol[2])
  );

  typedef struct {
    string       tag;
    logic        err;
    logic [63:0] rd;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_done = 0;
  logic [31:0] m0 [16];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rdata_of(input int d);
    case (d)
      0:       return {32'h0, prdata0};
      1:       return {32'h0, prdata1};
      default: return prdata2;
    endcase
  endfunction

  // Called #1 after a rising edge; returns #1 after the completing edge with the bus idle.
  task automatic xfer(input int d, input string tag, input logic wr, input logic [31:0] a,
                      input logic [63:0] wd, input logic [7:0] st, input logic [2:0] pr,
                      input logic exp_err, input logic [63:0] exp_rd);
    exp_t e;
    int   c;
    bit   done;
    e.tag = tag;
    e.err = exp_err;
    e.rd  = wr ? 64'h0 : exp_rd;
    e.lat = (d == 1) ? 4 : 1;
    sb.push_back(e);
    psel = '0; psel[d] = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = wd; pstrb = st; prot = pr;
    @(posedge clk); #1 penable = 1'b1;
    c = 0;
    done = 1'b0;
    while (!done && c < 40) begin
      @(negedge clk);
      c++;
      if (pready[d]) begin
        e = sb.pop_front();
        check({e.tag, " latency"}, 64'(c), 64'(e.lat));
        check({e.tag, " slverr"}, 64'(slverr[d]), 64'(e.err));
        check({e.tag, " prdata"}, rdata_of(d), e.rd);
        check({e.tag, " prot_viol"}, 64'(viol[d]), 64'h0);
        last_done = cyc;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      e = sb.pop_front();
      check({e.tag, " timeout"}, 64'h0, 64'h1);
    end
    psel = '0; penable = 1'b0;
  endtask

  task automatic mwr(input int idx, input logic [31:0] data, input logic [3:0] st);
    xfer(0, "dut0 wr", 1'b1, BASE + 32'(4 * idx), {32'h0, data}, {4'h0, st}, 3'b000, 1'b0, 64'h0);
    for (int b = 0; b < 4; b++) if (st[b]) m0[idx][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic mrd(input int idx);
    xfer(0, "dut0 rd", 1'b0, BASE + 32'(4 * idx), 64'h0, 8'h0, 3'b000, 1'b0, {32'h0, m0[idx]});
  endtask

  // mode 0: drop penable on the second ACCESS cycle; mode 1: move paddr instead.
  task automatic viol_test(input string tag, input int mode, input logic [31:0] a);
    psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = a;
    pwdata = 64'hBAD0_BAD0; pstrb = 8'h0F; prot = 3'b000;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    check({tag, " early pready"}, 64'(pready[1]), 64'h0);
    @(posedge clk); #1;
    if (mode == 0) penable = 1'b0;
    else paddr = a + 32'h4;
    @(negedge clk);
    check({tag, " prot_viol"}, 64'(viol[1]), 64'h1);
    check({tag, " no pready"}, 64'(pready[1]), 64'h0);
    @(posedge clk); #1 psel = '0; penable = 1'b0;
    @(negedge clk);
    check({tag, " pulse ends"}, 64'(viol[1]), 64'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1;
    rst = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
    pwdata = '0; pstrb = '0; prot = '0;
    for (int i = 0; i < 16; i++) m0[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset pready", {61'h0, pready}, 64'h0);
    check("reset slverr", {61'h0, slverr}, 64'h0);
    check("reset prdata", {32'h0, prdata0}, 64'h0);
    check("reset prot_viol", {61'h0, viol}, 64'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Basic write/read and byte strobes on the default instance.
    mwr(2, 32'hDEADBEEF, 4'hF);
    xfer(0, "read 0x08", 1'b0, BASE + 32'h08, 64'h0, 8'h0, 3'b000, 1'b0, 64'hDEADBEEF);
    mwr(4, 32'h11223344, 4'hF);
    mwr(4, 32'hAABBCCDD, 4'h5);
    xfer(0, "strobe merge", 1'b0, BASE + 32'h10, 64'h0, 8'h0, 3'b000, 1'b0, 64'h11BB33DD);

    // Error responses leave memory untouched.
    xfer(0, "read idx16", 1'b0, BASE + 32'h40, 64'h0, 8'h0, 3'b000, 1'b1, 64'h0);
    xfer(0, "wr misalign", 1'b1, BASE + 32'h02, 64'hFFFF_FFFF, 8'h0F, 3'b000, 1'b1, 64'h0);
    xfer(0, "read 0x00", 1'b0, BASE, 64'h0, 8'h0, 3'b000, 1'b0, 64'h0);
    xfer(0, "wr nonsecure", 1'b1, BASE + 32'h08, 64'h1234_5678, 8'h0F, 3'b010, 1'b1, 64'h0);
    xfer(0, "rd nonsecure", 1'b0, BASE + 32'h08, 64'h0, 8'h0, 3'b010, 1'b0, 64'hDEADBEEF);
    xfer(0, "wr below base", 1'b1, BASE - 32'h4, 64'h1, 8'h0F, 3'b000, 1'b1, 64'h0);
    mwr(4, 32'hFFFF_FFFF, 4'h0);
    xfer(0, "strb0 noop", 1'b0, BASE + 32'h10, 64'h0, 8'h0, 3'b000, 1'b0, 64'h11BB33DD);
    mwr(15, 32'hC0DE_F00D, 4'hF);
    mrd(15);

    for (int i = 0; i < 16; i++) begin
      int idx;
      idx = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) mwr(idx, $urandom, 4'($urandom_range(0, 15)));
      else mrd(idx);
    end

    // Wait states, throughput and protocol violations.
    xfer(1, "ws wr0", 1'b1, BASE, 64'h1234_5678, 8'h0F, 3'b000, 1'b0, 64'h0);
    t1 = last_done;
    xfer(1, "ws wr1", 1'b1, BASE + 32'h4, 64'h9ABC_DEF0, 8'h0F, 3'b000, 1'b0, 64'h0);
    check("ws back-to-back cycles", 64'(last_done - t1), 64'd5);
    viol_test("drop penable", 0, BASE);
    xfer(1, "ws rd0", 1'b0, BASE, 64'h0, 8'h0, 3'b000, 1'b0, 64'h1234_5678);
    viol_test("paddr change", 1, BASE + 32'h4);
    xfer(1, "ws rd1", 1'b0, BASE + 32'h4, 64'h0, 8'h0, 3'b000, 1'b0, 64'h9ABC_DEF0);

    // 64-bit instance: upper-half strobes, range edge, then reset mid-transfer.
    xfer(2, "w64 full", 1'b1, BASE + 32'h38, 64'h0123_4567_89AB_CDEF, 8'hFF, 3'b000, 1'b0, 64'h0);
    xfer(2, "w64 upper", 1'b1, BASE + 32'h38, 64'hCAFE_F00D_5555_AAAA, 8'hF0, 3'b000, 1'b0, 64'h0);
    xfer(2, "r64 0x38", 1'b0, BASE + 32'h38, 64'h0, 8'h0, 3'b000, 1'b0, 64'hCAFE_F00D_89AB_CDEF);
    xfer(2, "r64 idx8", 1'b0, BASE + 32'h40, 64'h0, 8'h0, 3'b000, 1'b1, 64'h0);

    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 32'h38;
    pwdata = 64'hFFFF_FFFF_FFFF_FFFF; pstrb = 8'hFF; prot = 3'b000;
    @(posedge clk); #1 penable = 1'b1;
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst pready", 64'(pready[2]), 64'h0);
    check("rst slverr", 64'(slverr[2]), 64'h0);
    check("rst prdata", prdata2, 64'h0);
    check("rst prot_viol", 64'(viol[2]), 64'h0);
    @(posedge clk); #1 rst = 1'b0; psel = '0; penable = 1'b0;
    for (int i = 0; i < 16; i++) m0[i] = '0;
    @(posedge clk); #1;
    xfer(2, "r64 cleared", 1'b0, BASE + 32'h38, 64'h0, 8'h0, 3'b000, 1'b0, 64'h0);
    mrd(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
